// File: rtl/birthday_seq_pkg.sv
// Shared types and default sizing for the birthday digit sequencer.
package birthday_seq_pkg;

  localparam int unsigned DEF_IDX_W   = 3;
  localparam int unsigned DEF_DIGITS  = 8;
  localparam int unsigned DEF_DWELL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHOW   = 2'd1,
    ST_FINISH = 2'd2
  } seq_state_e;

endpackage

// File: rtl/birthday_seq_ctrl_if.sv
// Control/ROM-side bundle for birthday_seq_ctrl; master drives commands and ROM data.
interface birthday_seq_ctrl_if
  import birthday_seq_pkg::*;
#(
  parameter int unsigned IDX_W   = DEF_IDX_W,
  parameter int unsigned DWELL_W = DEF_DWELL_W
);

  logic               start;
  logic               stop;
  logic               loop_en;
  logic [DWELL_W-1:0] dwell;
  logic [3:0]         digit_in;
  logic [IDX_W-1:0]   idx;
  logic               idx_valid;
  logic [3:0]         digit_out;
  logic               digit_strobe;
  logic               busy;
  logic               done;

  modport master (
    output start, stop, loop_en, dwell, digit_in,
    input  idx, idx_valid, digit_out, digit_strobe, busy, done
  );

  modport slave (
    input  start, stop, loop_en, dwell, digit_in,
    output idx, idx_valid, digit_out, digit_strobe, busy, done
  );

endinterface

// File: rtl/seq_dwell_timer.sv
// Per-digit dwell counter: counts up while enabled, flags the limit and the first cycle.
module seq_dwell_timer
  import birthday_seq_pkg::*;
#(
  parameter int unsigned W = DEF_DWELL_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_limit,
  output logic         o_expire,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = (r_cnt == i_limit);
  assign o_zero   = (r_cnt == '0);

endmodule

// File: rtl/birthday_seq_ctrl.sv
// Steps the digit ROM index with a programmable dwell, capturing and strobing each digit.
module birthday_seq_ctrl
  import birthday_seq_pkg::*;
#(
  parameter int unsigned IDX_W   = DEF_IDX_W,
  parameter int unsigned DIGITS  = DEF_DIGITS,
  parameter int unsigned DWELL_W = DEF_DWELL_W
) (
  input  logic                CLK,
  input  logic                rst_n,
  birthday_seq_ctrl_if.slave  bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  seq_state_e         r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic               r_idx_valid, w_idx_valid_nxt;
  logic [3:0]         r_digit, w_digit_nxt;
  logic               r_strobe, w_strobe_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic [DWELL_W-1:0] r_dwell_q, w_dwell_nxt;
  logic               r_loop_q, w_loop_nxt;
  logic               w_t_clr, w_t_en, w_expire, w_zero;

  seq_dwell_timer #(.W(DWELL_W)) u_timer (
    .clk      (CLK),
    .rst_n    (rst_n),
    .i_clr    (w_t_clr),
    .i_en     (w_t_en),
    .i_limit  (r_dwell_q),
    .o_expire (w_expire),
    .o_zero   (w_zero)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_idx_valid_nxt = r_idx_valid;
    w_digit_nxt     = r_digit;
    w_strobe_nxt    = 1'b0;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
    w_dwell_nxt     = r_dwell_q;
    w_loop_nxt      = r_loop_q;
    w_t_clr         = 1'b0;
    w_t_en          = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_dwell_nxt     = bus.dwell;
          w_loop_nxt      = bus.loop_en;
          w_idx_nxt       = '0;
          w_idx_valid_nxt = 1'b1;
          w_busy_nxt      = 1'b1;
          w_t_clr         = 1'b1;
          w_state_nxt     = ST_SHOW;
        end
      end

      ST_SHOW: begin
        if (bus.stop) begin
          w_idx_nxt       = '0;
          w_idx_valid_nxt = 1'b0;
          w_busy_nxt      = 1'b0;
          w_t_clr         = 1'b1;
          w_state_nxt     = ST_IDLE;
        end else begin
          // Capture and advance can share an edge when the dwell is a single cycle.
          if (w_zero) begin
            w_digit_nxt  = bus.digit_in;
            w_strobe_nxt = 1'b1;
          end
          if (w_expire) begin
            w_t_clr = 1'b1;
            if (r_idx != LAST_IDX) begin
              w_idx_nxt = r_idx + 1'b1;
            end else if (r_loop_q) begin
              w_idx_nxt = '0;
            end else begin
              w_idx_nxt       = '0;
              w_idx_valid_nxt = 1'b0;
              w_busy_nxt      = 1'b0;
              w_done_nxt      = 1'b1;
              w_state_nxt     = ST_FINISH;
            end
          end else begin
            w_t_en = 1'b1;
          end
        end
      end

      ST_FINISH: begin
        w_idx_nxt       = '0;
        w_idx_valid_nxt = 1'b0;
        w_busy_nxt      = 1'b0;
        w_state_nxt     = ST_IDLE;
      end

      default: begin
        w_idx_nxt       = '0;
        w_idx_valid_nxt = 1'b0;
        w_busy_nxt      = 1'b0;
        w_state_nxt     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_idx_valid <= 1'b0;
      r_digit     <= '0;
      r_strobe    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_dwell_q   <= '0;
      r_loop_q    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_idx_valid <= w_idx_valid_nxt;
      r_digit     <= w_digit_nxt;
      r_strobe    <= w_strobe_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_dwell_q   <= w_dwell_nxt;
      r_loop_q    <= w_loop_nxt;
    end
  end

  assign bus.idx          = r_idx;
  assign bus.idx_valid    = r_idx_valid;
  assign bus.digit_out    = r_digit;
  assign bus.digit_strobe = r_strobe;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;

endmodule

// File: tb/tb_birthday_seq_ctrl.sv
// Directed bench for birthday_seq_ctrl with a 2,0,0,1,0,9,1,5 ROM model.
module tb_birthday_seq_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  birthday_seq_ctrl_if #(.IDX_W(3), .DWELL_W(4)) bus ();

  birthday_seq_ctrl #(.IDX_W(3), .DIGITS(8), .DWELL_W(4)) dut (
    .CLK   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic [3:0] rom [8] = '{4'd2, 4'd0, 4'd0, 4'd1, 4'd0, 4'd9, 4'd1, 4'd5};
  assign bus.digit_in = rom[bus.idx];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.loop_en = 1'b0; bus.dwell = 4'd0;
    #3;
    checks++; if ({bus.idx, bus.idx_valid, bus.digit_out, bus.digit_strobe, bus.busy, bus.done} !== 11'd0) begin
      errors++; $display("FAIL reset_outputs got %h exp 0", {bus.idx, bus.idx_valid, bus.digit_out, bus.digit_strobe, bus.busy, bus.done});
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.idx !== 3'd0) begin
      errors++; $display("FAIL reset_idle busy=%b idx=%0d exp 0/0", bus.busy, bus.idx);
    end
  endtask

  task automatic test_oneshot(input int d, input string tag);
    int total, nstrobe, ndone;
    logic exp_busy, exp_strobe, exp_done;
    logic [2:0] exp_idx;
    bus.dwell = 4'(d); bus.loop_en = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    total = 8 * (d + 1); nstrobe = 0; ndone = 0;
    for (int c = 0; c < total + 3; c++) begin
      exp_busy   = (c < total);
      exp_idx    = exp_busy ? 3'(c / (d + 1)) : 3'd0;
      exp_strobe = (c >= 1) && ((c - 1) % (d + 1) == 0) && ((c - 1) < total);
      exp_done   = (c == total);
      checks++; if (bus.busy !== exp_busy) begin errors++; $display("FAIL %s busy c=%0d got %b exp %b", tag, c, bus.busy, exp_busy); end
      checks++; if (bus.idx_valid !== exp_busy) begin errors++; $display("FAIL %s idx_valid c=%0d got %b exp %b", tag, c, bus.idx_valid, exp_busy); end
      checks++; if (bus.idx !== exp_idx) begin errors++; $display("FAIL %s idx c=%0d got %0d exp %0d", tag, c, bus.idx, exp_idx); end
      checks++; if (bus.digit_strobe !== exp_strobe) begin errors++; $display("FAIL %s strobe c=%0d got %b exp %b", tag, c, bus.digit_strobe, exp_strobe); end
      checks++; if (bus.done !== exp_done) begin errors++; $display("FAIL %s done c=%0d got %b exp %b", tag, c, bus.done, exp_done); end
      if (bus.digit_strobe === 1'b1) begin
        nstrobe++;
        checks++; if (bus.digit_out !== rom[(c - 1) / (d + 1)]) begin
          errors++; $display("FAIL %s digit c=%0d got %0d exp %0d", tag, c, bus.digit_out, rom[(c - 1) / (d + 1)]);
        end
      end
      if (bus.done === 1'b1) ndone++;
      tick();
    end
    checks++; if (nstrobe !== 8) begin errors++; $display("FAIL %s strobe_count got %0d exp 8", tag, nstrobe); end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL %s done_count got %0d exp 1", tag, ndone); end
  endtask

  task automatic test_loop_stop();
    logic exp_strobe;
    logic [2:0] exp_idx;
    bus.dwell = 4'd1; bus.loop_en = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 26; c++) begin
      exp_idx    = 3'((c / 2) % 8);
      exp_strobe = (c >= 1) && ((c - 1) % 2 == 0);
      checks++; if (bus.idx !== exp_idx) begin errors++; $display("FAIL loop idx c=%0d got %0d exp %0d", c, bus.idx, exp_idx); end
      checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL loop busy_done c=%0d got %b%b exp 10", c, bus.busy, bus.done); end
      checks++; if (bus.digit_strobe !== exp_strobe) begin errors++; $display("FAIL loop strobe c=%0d got %b exp %b", c, bus.digit_strobe, exp_strobe); end
      if (exp_strobe) begin
        checks++; if (bus.digit_out !== rom[((c - 1) / 2) % 8]) begin
          errors++; $display("FAIL loop digit c=%0d got %0d exp %0d", c, bus.digit_out, rom[((c - 1) / 2) % 8]);
        end
      end
      tick();
    end
    checks++; if (bus.idx !== 3'd5) begin errors++; $display("FAIL loop pre_stop idx got %0d exp 5", bus.idx); end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    checks++; if ({bus.idx, bus.idx_valid, bus.busy, bus.done, bus.digit_strobe} !== 7'd0) begin
      errors++; $display("FAIL loop stop got idx=%0d v=%b b=%b d=%b s=%b exp all 0", bus.idx, bus.idx_valid, bus.busy, bus.done, bus.digit_strobe);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL loop after_stop c=%0d got %b%b exp 00", c, bus.busy, bus.done); end
    end
  endtask

  task automatic test_midrun();
    logic exp_busy;
    logic [2:0] exp_idx;
    int waited;
    bus.dwell = 4'd1; bus.loop_en = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      exp_busy = (c < 16);
      exp_idx  = exp_busy ? 3'(c / 2) : 3'd0;
      checks++; if (bus.busy !== exp_busy) begin errors++; $display("FAIL mid busy c=%0d got %b exp %b", c, bus.busy, exp_busy); end
      checks++; if (bus.idx !== exp_idx) begin errors++; $display("FAIL mid idx c=%0d got %0d exp %0d", c, bus.idx, exp_idx); end
      checks++; if (bus.done !== (c == 16)) begin errors++; $display("FAIL mid done c=%0d got %b exp %b", c, bus.done, (c == 16)); end
      if (c == 3) begin bus.start = 1'b1; bus.dwell = 4'd7; bus.loop_en = 1'b1; end
      if (c == 4) bus.start = 1'b0;
      if (c == 16) bus.start = 1'b1;
      if (c == 17) bus.start = 1'b0;
      tick();
    end
    bus.dwell = 4'd0; bus.loop_en = 1'b0; bus.start = 1'b1; bus.stop = 1'b1;
    tick();
    bus.start = 1'b0; bus.stop = 1'b0;
    checks++; if (bus.busy !== 1'b1 || bus.idx_valid !== 1'b1 || bus.idx !== 3'd0) begin
      errors++; $display("FAIL mid start_stop got busy=%b v=%b idx=%0d exp 1/1/0", bus.busy, bus.idx_valid, bus.idx);
    end
    waited = 0;
    while (bus.done !== 1'b1 && waited < 20) begin tick(); waited++; end
    checks++; if (waited !== 8) begin errors++; $display("FAIL mid start_stop_len got %0d exp 8", waited); end
    tick();
  endtask

  task automatic test_async_reset();
    bus.dwell = 4'd1; bus.loop_en = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (6) tick();
    checks++; if (bus.idx !== 3'd3) begin errors++; $display("FAIL arst pre idx got %0d exp 3", bus.idx); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({bus.idx, bus.idx_valid, bus.digit_out, bus.digit_strobe, bus.busy, bus.done} !== 11'd0) begin
      errors++; $display("FAIL arst outputs got %h exp 0", {bus.idx, bus.idx_valid, bus.digit_out, bus.digit_strobe, bus.busy, bus.done});
    end
    #2 rst_n = 1'b1;
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.digit_out !== 4'd0) begin
      errors++; $display("FAIL arst idle got busy=%b digit=%0d exp 0/0", bus.busy, bus.digit_out);
    end
    test_oneshot(0, "arst_run");
  endtask

  task automatic test_stop_final();
    bus.dwell = 4'd0; bus.loop_en = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (7) tick();
    checks++; if (bus.idx !== 3'd7) begin errors++; $display("FAIL sfin pre idx got %0d exp 7", bus.idx); end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    checks++; if ({bus.idx, bus.busy, bus.done, bus.digit_strobe} !== 6'd0) begin
      errors++; $display("FAIL sfin stop got idx=%0d b=%b d=%b s=%b exp all 0", bus.idx, bus.busy, bus.done, bus.digit_strobe);
    end
    checks++; if (bus.digit_out !== 4'd1) begin errors++; $display("FAIL sfin digit_hold got %0d exp 1", bus.digit_out); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL sfin late_done c=%0d got %b exp 0", c, bus.done); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_oneshot(0, "oneshot_d0");
    checks++; if (bus.digit_out !== 4'd5) begin errors++; $display("FAIL idle digit_hold got %0d exp 5", bus.digit_out); end
    test_oneshot(3, "oneshot_d3");
    test_loop_stop();
    test_midrun();
    test_async_reset();
    test_stop_final();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
